// File: rtl/layer_sched_if.sv
// Scheduler-to-layer-controller link: descriptor outputs, start pulse, controller reset, done flag.
// Field-width defaults come from the W_SIZE / W_CHANNEL / W_FRAME_SIZE macros when not predefined.
`ifndef W_SIZE
`define W_SIZE 8
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 8
`endif
`ifndef W_FRAME_SIZE
`define W_FRAME_SIZE 20
`endif

interface layer_sched_if #(
  parameter int W_SIZE       = `W_SIZE,
  parameter int W_CHANNEL    = `W_CHANNEL,
  parameter int W_FRAME_SIZE = `W_FRAME_SIZE
);
  logic [W_SIZE-1:0]       o_q_width;
  logic [W_SIZE-1:0]       o_q_height;
  logic [W_CHANNEL-1:0]    o_q_channel;
  logic [W_CHANNEL-1:0]    o_q_channel_out;
  logic [W_FRAME_SIZE-1:0] o_q_frame_size;
  logic                    o_q_start;
  logic                    o_ctrl_rstn;
  logic                    i_layer_done;

  modport master (
    output o_q_width, o_q_height, o_q_channel, o_q_channel_out,
    output o_q_frame_size, o_q_start, o_ctrl_rstn,
    input  i_layer_done
  );

  modport slave (
    input  o_q_width, o_q_height, o_q_channel, o_q_channel_out,
    input  o_q_frame_size, o_q_start, o_ctrl_rstn,
    output i_layer_done
  );
endinterface

// File: rtl/layer_sched.sv
// Layer sequencer: walks a descriptor table, starts the layer controller per entry, waits for its
// done edge and pulses the controller reset. Optional RUN watchdog: define LAYER_SCHED_TIMEOUT_EN.
`ifndef W_SIZE
`define W_SIZE 8
`endif
`ifndef W_CHANNEL
`define W_CHANNEL 8
`endif
`ifndef W_FRAME_SIZE
`define W_FRAME_SIZE 20
`endif

module layer_sched #(
  parameter int W_SIZE       = `W_SIZE,
  parameter int W_CHANNEL    = `W_CHANNEL,
  parameter int W_FRAME_SIZE = `W_FRAME_SIZE,
  parameter int W_LAYER      = 4,
  parameter int TIMEOUT      = 2**20
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_desc_we,
  input  logic [W_LAYER-1:0]   i_desc_addr,
  input  logic [W_SIZE-1:0]    i_desc_width,
  input  logic [W_SIZE-1:0]    i_desc_height,
  input  logic [W_CHANNEL-1:0] i_desc_channel,
  input  logic [W_CHANNEL-1:0] i_desc_channel_out,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [W_LAYER:0]     i_num_layers,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [W_LAYER-1:0]   o_layer_idx,
  layer_sched_if.master        ctrl
);
  localparam int N_LAYER = 2**W_LAYER;
  localparam int PW      = 2*W_SIZE + W_CHANNEL;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    CLR   = 3'd4,
    DONE  = 3'd5
  } state_t;

  logic [W_SIZE-1:0]       tbl_width_r  [N_LAYER];
  logic [W_SIZE-1:0]       tbl_height_r [N_LAYER];
  logic [W_CHANNEL-1:0]    tbl_ch_r     [N_LAYER];
  logic [W_CHANNEL-1:0]    tbl_chout_r  [N_LAYER];

  state_t                  state_r, state_s;
  logic [W_LAYER-1:0]      idx_r, idx_s;
  logic [W_LAYER:0]        num_r;
  logic                    clr_cnt_r, abort_r, prev_done_r;
  logic                    busy_r, done_r, q_start_r, ctrl_rstn_r;
  logic                    edge_s, last_s, timeout_s, error_s;
  logic [W_SIZE-1:0]       q_width_r, q_height_r;
  logic [W_CHANNEL-1:0]    q_ch_r, q_chout_r;
  logic [W_FRAME_SIZE-1:0] q_frame_r;
  logic [PW-1:0]           prod_s;

  // Descriptor table write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (i_desc_we) begin
      tbl_width_r[i_desc_addr]  <= i_desc_width;
      tbl_height_r[i_desc_addr] <= i_desc_height;
      tbl_ch_r[i_desc_addr]     <= i_desc_channel;
      tbl_chout_r[i_desc_addr]  <= i_desc_channel_out;
    end
  end

  assign edge_s = ctrl.i_layer_done && !prev_done_r;
  assign last_s = ({1'b0, idx_r} + {{W_LAYER{1'b0}}, 1'b1}) >= num_r;
  assign prod_s = PW'(tbl_width_r[idx_r]) * PW'(tbl_height_r[idx_r]) * PW'(tbl_ch_r[idx_r]);

`ifdef LAYER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_r;
  logic          error_r;

  // RUN-cycle watchdog, restarted on every entry into RUN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt_r <= {TW{1'b0}};
    end else if (state_r == RUN) begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end else begin
      to_cnt_r <= {TW{1'b0}};
    end
  end

  assign timeout_s = (state_r == RUN) && (to_cnt_r == TW'(TIMEOUT - 1)) && !edge_s;

  // Sticky error flag, cleared only by an accepted start
  always_ff @(posedge clk) begin
    if (!rstn) begin
      error_r <= 1'b0;
    end else if ((state_r == IDLE) && i_start) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end
  end

  assign error_s = error_r;
`else
  assign timeout_s = 1'b0;
  assign error_s   = 1'b0;
`endif

  // Next-state logic; abort (and timeout) route through CLR so the controller always gets cleared
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          idx_s   = {W_LAYER{1'b0}};
          state_s = (i_num_layers != {(W_LAYER+1){1'b0}}) ? LOAD : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = i_abort ? CLR : START;
      START: state_s = i_abort ? CLR : RUN;
      RUN: begin
        if (i_abort || edge_s || timeout_s) begin
          state_s = CLR;
        end else begin
          state_s = RUN;
        end
      end
      CLR: begin
        if (!clr_cnt_r) begin
          state_s = CLR;
        end else if (abort_r || i_abort) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = LOAD;
          idx_s   = idx_r + {{(W_LAYER-1){1'b0}}, 1'b1};
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      idx_r       <= {W_LAYER{1'b0}};
      num_r       <= {(W_LAYER+1){1'b0}};
      clr_cnt_r   <= 1'b0;
      abort_r     <= 1'b0;
      prev_done_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      q_start_r   <= 1'b0;
      ctrl_rstn_r <= 1'b0;
      q_width_r   <= {W_SIZE{1'b0}};
      q_height_r  <= {W_SIZE{1'b0}};
      q_ch_r      <= {W_CHANNEL{1'b0}};
      q_chout_r   <= {W_CHANNEL{1'b0}};
      q_frame_r   <= {W_FRAME_SIZE{1'b0}};
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      prev_done_r <= ctrl.i_layer_done;
      clr_cnt_r   <= (state_r == CLR) && !clr_cnt_r;
      busy_r      <= (state_s == LOAD) || (state_s == START) || (state_s == RUN) || (state_s == CLR);
      done_r      <= (state_s == DONE);
      q_start_r   <= (state_s == START);
      ctrl_rstn_r <= (state_s != CLR);
      if ((state_r == IDLE) && i_start) begin
        num_r <= i_num_layers;
      end
      if ((state_r == IDLE) || (state_s == IDLE)) begin
        abort_r <= 1'b0;
      end else if (i_abort || timeout_s) begin
        abort_r <= 1'b1;
      end
      if (state_r == LOAD) begin
        q_width_r  <= tbl_width_r[idx_r];
        q_height_r <= tbl_height_r[idx_r];
        q_ch_r     <= tbl_ch_r[idx_r];
        q_chout_r  <= tbl_chout_r[idx_r];
        q_frame_r  <= W_FRAME_SIZE'(prod_s);
      end
    end
  end

  assign o_busy               = busy_r;
  assign o_done               = done_r;
  assign o_error              = error_s;
  assign o_layer_idx          = idx_r;
  assign ctrl.o_q_width       = q_width_r;
  assign ctrl.o_q_height      = q_height_r;
  assign ctrl.o_q_channel     = q_ch_r;
  assign ctrl.o_q_channel_out = q_chout_r;
  assign ctrl.o_q_frame_size  = q_frame_r;
  assign ctrl.o_q_start       = q_start_r;
  assign ctrl.o_ctrl_rstn     = ctrl_rstn_r;
endmodule
